param_mem: RTL and testbench
============================

// Module: param_mem
// PURPOSE
//  Parametrised single-port word memory with per-word valid tracking, occupancy flags and a
//  background clear sequencer. Generalises the fixed 32x32 memory to any width and depth.
//  Sits behind the mem_if bus; the same empty/full/half_full semantics apply at any size.
// PARAMETERS
//  DATA_W    32        data word width in bits (>=1)
//  DEPTH     32        number of words (>=2, need not be a power of 2)
//  HALF_THR  DEPTH/2   count at or above which half_full asserts
//  AW        $clog2(DEPTH)  localparam: address width
// PORTS
//  clk        in   1        rising-edge clock
//  rst        in   1        asynchronous, active-high reset
//  wr_en      in   1        write request, sampled at posedge clk
//  rd_en      in   1        read request, sampled at posedge clk
//  clr_req    in   1        start background clear (single-cycle pulse is sufficient)
//  addr       in   AW       word address shared by read and write
//  wr_data    in   DATA_W   write data
//  data_out   out  DATA_W   read data, valid when rd_valid=1
//  rd_valid   out  1        one-cycle pulse: data_out carries a read response
//  rd_err     out  1        with rd_valid: word never written, out of range, or memory busy
//  wr_err     out  1        one-cycle pulse: write dropped (busy or addr>=DEPTH)
//  par_err    out  1        with rd_valid: stored parity mismatch (see CONFIGURATION)
//  busy       out  1        clear sweep in progress
//  count      out  AW+1     number of valid words
//  full       out  1        count==DEPTH
//  empty      out  1        count==0
//  half_full  out  1        count>=HALF_THR
// BEHAVIOUR
//  Reset (async assert, sync release): data_out=0, rd_valid=0, rd_err=0, wr_err=0, par_err=0,
//    busy=0, count=0, empty=1, full=0, half_full=0, FSM=IDLE, all valid bits 0.
//    RAM array is not reset. Reset mid-clear aborts the sweep.
//  Flags are decoded from the registered count: they change the cycle after the causing write.
//  Write (wr_en & !busy & addr<DEPTH): mem[addr]<=wr_data. If valid[addr]==0, set it and
//    increment count. Overwriting a valid word leaves count unchanged; full never exceeds DEPTH.
//  Dropped write (busy, or addr>=DEPTH): array is untouched; wr_err=1 on the next cycle.
//  Read: latency 1. rd_en at edge N -> rd_valid=1 at N+1.
//    Valid word: data_out=mem[addr], rd_err=0.
//    Invalid word, addr>=DEPTH, or busy: data_out=0, rd_err=1.
//    data_out holds its last value while rd_valid=0; it is never X after reset.
//  Read and write to the same addr in one cycle: read-first (old data). If the word was
//    invalid, the response is 0 with rd_err=1.
//  Clear FSM (states in mem_pkg): IDLE, CLEAR.
//    IDLE -> CLEAR on clr_req; a write in the same cycle is performed first.
//    CLEAR: busy=1; idx steps 0..DEPTH-1, one word per cycle; valid[idx]<=0;
//      count decrements if the bit was set.
//    CLEAR -> IDLE after idx==DEPTH-1. Count is then 0; busy drops on the following cycle.
//    The sweep takes DEPTH cycles. clr_req while in CLEAR is ignored.
// CONFIGURATION
//  MEM_PARITY_EN defined: one extra even-parity bit is stored per word (^wr_data).
//    On a valid read, par_err=1 together with rd_valid if the recomputed parity differs.
//    Data is still returned.
//  Not defined: no parity storage; par_err is tied to 0.
// STRUCTURE
//  mem_pkg: clr_state_e enum {IDLE, CLEAR}, and a function computing the address width
//    from depth.
//  Sub-module mem_occupancy: valid-bit vector, count register and flag decode.
//    It takes set and clear strobes with an index.
//  Top level: RAM array, read path, clear FSM and error pulses.
// TESTING
//  Reset: pulse rst for 3 cycles during a clear sweep.
//    -> empty=1, count=0, busy=0, rd_valid=0, data_out=0.
//  Basic access: write 32'hDEADBEEF @5.
//    -> next cycle empty=0, count=1.
//    Read @5 -> next cycle rd_valid=1, data_out=32'hDEADBEEF, rd_err=0.
//  Unwritten and out-of-range reads: read @7 after reset -> data_out=0, rd_err=1.
//    With DEPTH=24, read @30 -> rd_err=1; write @30 -> wr_err=1, count unchanged.
//  Fill: write all 32 addresses.
//    -> half_full rises the cycle after the 16th write; full rises after the 32nd.
//    Rewrite @0 -> count stays 32.
//  Clear: clr_req with count=32 -> busy=1 for 32 cycles, then empty=1, count=0.
//    wr_en during the sweep -> wr_err=1 and the array is untouched.
//  Read-first and parity: @3 holds 1; write 2 and read @3 in the same cycle -> data_out=1.
//    The next read returns 2.
//    With MEM_PARITY_EN, flip a bit in a stored word by hierarchical deposit, then read it
//    -> par_err=1.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and helpers for the parametrised word memory.
package mem_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } clr_state_e;

   // Address width for a given depth; never less than one bit.
   function automatic int addr_width(input int depth);
      int w;
      w = 1;
      while ((1 << w) < depth) w++;
      return w;
   endfunction

endpackage

// File: rtl/mem_occupancy.sv
// Per-word valid bits, occupancy count and empty/full/half_full decode.
module mem_occupancy
   import mem_pkg::*;
#(
   parameter  int DEPTH    = 32,
   parameter  int HALF_THR = DEPTH / 2,
   localparam int AW       = addr_width(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             set_en,
   input  logic [AW-1:0]    set_idx,
   input  logic             clr_en,
   input  logic [AW-1:0]    clr_idx,
   output logic [DEPTH-1:0] valid,
   output logic [AW:0]      count,
   output logic             full,
   output logic             empty,
   output logic             half_full
);

   localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [AW:0] HALF_CNT = (AW+1)'(HALF_THR);

   logic [DEPTH-1:0] valid_q, valid_d;
   logic [AW:0]      count_q, count_d;

   // Clear is applied before set so a same-index pair leaves the word valid.
   always_comb begin
      valid_d = valid_q;
      count_d = count_q;
      if (clr_en && valid_d[clr_idx]) begin
         valid_d[clr_idx] = 1'b0;
         count_d          = count_d - CNT_ONE;
      end
      if (set_en && !valid_d[set_idx]) begin
         valid_d[set_idx] = 1'b1;
         count_d          = count_d + CNT_ONE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
         count_q <= '0;
      end else begin
         valid_q <= valid_d;
         count_q <= count_d;
      end
   end

   assign valid     = valid_q;
   assign count     = count_q;
   assign full      = (count_q == FULL_CNT);
   assign empty     = (count_q == '0);
   assign half_full = (count_q >= HALF_CNT);

endmodule

// File: rtl/param_mem.sv
// Parametrised single-port word memory with valid tracking and a background clear sweep.
// Optional stored even parity per word when MEM_PARITY_EN is defined.
module param_mem
   import mem_pkg::*;
#(
   parameter  int DATA_W   = 32,
   parameter  int DEPTH    = 32,
   parameter  int HALF_THR = DEPTH / 2,
   localparam int AW       = addr_width(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic              rd_en,
   input  logic              clr_req,
   input  logic [AW-1:0]     addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic [DATA_W-1:0] data_out,
   output logic              rd_valid,
   output logic              rd_err,
   output logic              wr_err,
   output logic              par_err,
   output logic              busy,
   output logic [AW:0]       count,
   output logic              full,
   output logic              empty,
   output logic              half_full
);

   localparam logic [AW:0]   DEPTH_C  = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
   localparam logic [AW-1:0] IDX_ONE  = AW'(1);

   logic [DATA_W-1:0] mem [DEPTH];

   clr_state_e        state_q, state_d;
   logic [AW-1:0]     idx_q, idx_d;
   logic              clr_en;
   logic [DEPTH-1:0]  valid;
   logic              in_range, wr_ok, rd_ok;

   logic [DATA_W-1:0] data_out_q, data_out_d;
   logic              rd_valid_q, rd_valid_d;
   logic              rd_err_q, rd_err_d;
   logic              wr_err_q, wr_err_d;

   assign in_range = ({1'b0, addr} < DEPTH_C);
   assign busy     = (state_q == CLEAR);
   assign wr_ok    = wr_en & ~busy & in_range;
   assign rd_ok    = ~busy & in_range & valid[addr];

   mem_occupancy #(
      .DEPTH    (DEPTH),
      .HALF_THR (HALF_THR)
   ) u_occ (
      .clk       (clk),
      .rst       (rst),
      .set_en    (wr_ok),
      .set_idx   (addr),
      .clr_en    (clr_en),
      .clr_idx   (idx_q),
      .valid     (valid),
      .count     (count),
      .full      (full),
      .empty     (empty),
      .half_full (half_full)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      clr_en  = 1'b0;
      case (state_q)
         IDLE: begin
            if (clr_req) begin
               state_d = CLEAR;
               idx_d   = '0;
            end
         end
         CLEAR: begin
            clr_en = 1'b1;
            if (idx_q == LAST_IDX) state_d = IDLE;
            else                   idx_d   = idx_q + IDX_ONE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   // The array is sampled before this edge's write lands, giving read-first behaviour.
   always_comb begin
      data_out_d = data_out_q;
      rd_valid_d = rd_en;
      rd_err_d   = rd_en & ~rd_ok;
      wr_err_d   = wr_en & ~wr_ok;
      if (rd_en) data_out_d = rd_ok ? mem[addr] : '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_out_q <= '0;
         rd_valid_q <= 1'b0;
         rd_err_q   <= 1'b0;
         wr_err_q   <= 1'b0;
      end else begin
         data_out_q <= data_out_d;
         rd_valid_q <= rd_valid_d;
         rd_err_q   <= rd_err_d;
         wr_err_q   <= wr_err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_ok) mem[addr] <= wr_data;
   end

   assign data_out = data_out_q;
   assign rd_valid = rd_valid_q;
   assign rd_err   = rd_err_q;
   assign wr_err   = wr_err_q;

`ifdef MEM_PARITY_EN
   logic par_mem [DEPTH];
   logic par_err_q, par_err_d;

   assign par_err_d = rd_en & rd_ok & ((^mem[addr]) != par_mem[addr]);

   always_ff @(posedge clk) begin
      if (wr_ok) par_mem[addr] <= ^wr_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) par_err_q <= 1'b0;
      else     par_err_q <= par_err_d;
   end

   assign par_err = par_err_q;
`else
   assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_param_mem.sv
// Scoreboard bench for param_mem (32x32 instance plus a DEPTH=24 instance for range checks).
module tb_param_mem;

   localparam int DW    = 32;
   localparam int DEPTH = 32;
   localparam int AW    = 5;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          wr_en = 1'b0, rd_en = 1'b0, clr_req = 1'b0;
   logic [AW-1:0] addr = '0;
   logic [DW-1:0] wr_data = '0;
   logic [DW-1:0] data_out;
   logic          rd_valid, rd_err, wr_err, par_err, busy, full, empty, half_full;
   logic [AW:0]   count;

   logic          wr_en24 = 1'b0, rd_en24 = 1'b0, clr_req24 = 1'b0;
   logic [4:0]    addr24 = '0;
   logic [DW-1:0] wr_data24 = '0;
   logic [DW-1:0] data_out24;
   logic          rd_valid24, rd_err24, wr_err24, par_err24, busy24, full24, empty24, half_full24;
   logic [5:0]    count24;

   always #5 clk = ~clk;

   param_mem #(.DATA_W(DW), .DEPTH(DEPTH)) u_dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .clr_req(clr_req),
      .addr(addr), .wr_data(wr_data), .data_out(data_out), .rd_valid(rd_valid),
      .rd_err(rd_err), .wr_err(wr_err), .par_err(par_err), .busy(busy),
      .count(count), .full(full), .empty(empty), .half_full(half_full)
   );

   param_mem #(.DATA_W(DW), .DEPTH(24)) u_dut24 (
      .clk(clk), .rst(rst), .wr_en(wr_en24), .rd_en(rd_en24), .clr_req(clr_req24),
      .addr(addr24), .wr_data(wr_data24), .data_out(data_out24), .rd_valid(rd_valid24),
      .rd_err(rd_err24), .wr_err(wr_err24), .par_err(par_err24), .busy(busy24),
      .count(count24), .full(full24), .empty(empty24), .half_full(half_full24)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [DW-1:0] data;
      logic          err;
      logic          par;
   } exp_t;
   exp_t sb[$];

   logic [DW-1:0] model_mem [DEPTH];
   logic          model_valid [DEPTH];
   int            model_count = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end else begin
         $display("ok   %s: %0h", tag, obs);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      @(negedge clk);
      wr_en   = 1'b0;
      rd_en   = 1'b0;
      clr_req = 1'b0;
      wr_en24 = 1'b0;
      rd_en24 = 1'b0;
   endtask

   task automatic model_clear();
      for (int i = 0; i < DEPTH; i++) model_valid[i] = 1'b0;
      model_count = 0;
   endtask

   // Reads must be driven before a same-cycle write so the model sees old data.
   task automatic drive_read(input int a, input bit busy_now);
      exp_t e;
      rd_en = 1'b1;
      addr  = AW'(a);
      if (busy_now || a >= DEPTH || !model_valid[a]) begin
         e.data = '0;
         e.err  = 1'b1;
      end else begin
         e.data = model_mem[a];
         e.err  = 1'b0;
      end
      e.par = 1'b0;
      sb.push_back(e);
   endtask

   task automatic drive_write(input int a, input logic [DW-1:0] d);
      wr_en   = 1'b1;
      addr    = AW'(a);
      wr_data = d;
      if (!model_valid[a]) model_count++;
      model_valid[a] = 1'b1;
      model_mem[a]   = d;
   endtask

   always @(negedge clk) begin
      if (rd_valid) begin
         if (sb.size() == 0) begin
            check("spurious_rd_valid", 64'(rd_valid), 64'(0));
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("rd_data", 64'(data_out), 64'(e.data));
            check("rd_err", 64'(rd_err), 64'(e.err));
            check("par_err", 64'(par_err), 64'(e.par));
         end
      end
   end

   initial begin
      int busy_cycles;
      logic [DW-1:0] keep9;
      model_clear();

      // Power-on reset
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("rst_empty", 64'(empty), 64'(1));
      check("rst_count", 64'(count), 64'(0));
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_full", 64'(full), 64'(0));
      check("rst_half", 64'(half_full), 64'(0));
      check("rst_rd_valid", 64'(rd_valid), 64'(0));
      check("rst_data_out", 64'(data_out), 64'(0));

      // Unwritten read, then basic write/read
      drive_read(7, 1'b0);
      cycle();
      drive_write(5, 32'hDEADBEEF);
      cycle();
      check("wr5_count", 64'(count), 64'(1));
      check("wr5_empty", 64'(empty), 64'(0));
      drive_read(5, 1'b0);
      cycle();
      cycle();
      check("data_out_hold", 64'(data_out), 64'(32'hDEADBEEF));
      check("idle_rd_valid", 64'(rd_valid), 64'(0));

      // Out-of-range on DEPTH=24 instance
      rd_en24 = 1'b1;
      addr24  = 5'd30;
      cycle();
      check("d24_rd_valid", 64'(rd_valid24), 64'(1));
      check("d24_rd_err", 64'(rd_err24), 64'(1));
      check("d24_rd_data", 64'(data_out24), 64'(0));
      wr_en24   = 1'b1;
      addr24    = 5'd30;
      wr_data24 = 32'h1234;
      cycle();
      check("d24_wr_err", 64'(wr_err24), 64'(1));
      cycle();
      check("d24_wr_err_pulse", 64'(wr_err24), 64'(0));
      check("d24_count", 64'(count24), 64'(0));
      wr_en24   = 1'b1;
      addr24    = 5'd23;
      cycle();
      check("d24_wr_top_ok", 64'(wr_err24), 64'(0));
      cycle();
      check("d24_count_top", 64'(count24), 64'(1));

      // Reset in the middle of a clear sweep
      clr_req = 1'b1;
      cycle();
      check("sweep_busy", 64'(busy), 64'(1));
      repeat (3) cycle();
      rst = 1'b1;
      repeat (3) cycle();
      rst = 1'b0;
      model_clear();
      check("rstclr_empty", 64'(empty), 64'(1));
      check("rstclr_count", 64'(count), 64'(0));
      check("rstclr_busy", 64'(busy), 64'(0));
      check("rstclr_rd_valid", 64'(rd_valid), 64'(0));
      check("rstclr_data_out", 64'(data_out), 64'(0));
      cycle();
      check("rstclr_busy_after", 64'(busy), 64'(0));
      drive_read(5, 1'b0);
      cycle();

      // Fill every word
      for (int i = 0; i < DEPTH; i++) begin
         drive_write(i, $urandom);
         cycle();
         check("fill_count", 64'(count), 64'(model_count));
         check("fill_half", 64'(half_full), 64'(model_count >= DEPTH / 2));
         check("fill_full", 64'(full), 64'(model_count == DEPTH));
      end
      drive_write(0, 32'hA5A5_0000);
      cycle();
      check("rewrite_count", 64'(count), 64'(32));
      check("rewrite_full", 64'(full), 64'(1));
      foreach (model_mem[i]) if (i % 7 == 0) begin
         drive_read(i, 1'b0);
         cycle();
      end

      // Read-first on a same-cycle read/write
      drive_write(3, 32'd1);
      cycle();
      drive_read(3, 1'b0);
      drive_write(3, 32'd2);
      cycle();
      drive_read(3, 1'b0);
      cycle();
      cycle();

      // Clear sweep; a write in the request cycle lands first
      keep9   = 32'hC0FFEE09;
      clr_req = 1'b1;
      drive_write(9, keep9);
      cycle();
      model_clear();
      busy_cycles = 0;
      while (busy && busy_cycles < 100) begin
         busy_cycles++;
         if (busy_cycles == 1) begin
            wr_en   = 1'b1;
            addr    = AW'(9);
            wr_data = 32'h5555_5555;
         end
         if (busy_cycles == 2) begin
            check("busy_wr_err", 64'(wr_err), 64'(1));
            drive_read(9, 1'b1);
         end
         if (busy_cycles == 3) clr_req = 1'b1;
         cycle();
      end
      check("sweep_cycles", 64'(busy_cycles), 64'(DEPTH));
      check("sweep_empty", 64'(empty), 64'(1));
      check("sweep_count", 64'(count), 64'(0));
      check("sweep_untouched", 64'(u_dut.mem[9]), 64'(keep9));
      cycle();
      check("sweep_no_restart", 64'(busy), 64'(0));
      drive_read(9, 1'b0);
      cycle();

`ifdef MEM_PARITY_EN
      begin
         exp_t e;
         drive_write(4, 32'h0000_00F0);
         cycle();
         u_dut.mem[4] = u_dut.mem[4] ^ 32'h1;
         rd_en  = 1'b1;
         addr   = AW'(4);
         e.data = 32'h0000_00F1;
         e.err  = 1'b0;
         e.par  = 1'b1;
         sb.push_back(e);
         cycle();
      end
`endif

      repeat (3) cycle();
      check("sb_drained", 64'(sb.size()), 64'(0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
